// File: rtl/k052109_slot_seq.sv
// k052109_slot_seq: raster counters and VRAM access-slot sequencer for the
// 052109 tilemap model. Each 8-pixel character cell is split into FIX, layer A,
// layer B and CPU slots; the select pairs, tile operands and CPU arbiter state
// are all registered and advance only on pixel-enable ticks.
//
// CPU handshake: i_cpu_req is raised by the requester and held high until
// o_cpu_ack. o_cpu_ack is a single-CLK pulse marking completion. A grant lasts
// two ticks, always starts on an even CPU-slot phase, and cannot be aborted by
// dropping the request.
module k052109_slot_seq #(
   parameter int H_TOTAL  = 384,
   parameter int H_ACTIVE = 320,
   parameter int V_TOTAL  = 264,
   parameter int V_ACTIVE = 224
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pxl_en,
   input  logic [8:0] i_scrx_a,
   input  logic [7:0] i_scry_a,
   input  logic [8:0] i_scrx_b,
   input  logic [7:0] i_scry_b,
   input  logic       i_cpu_req,
   output logic       o_cpu_ack,
   output logic [8:0] o_hcnt,
   output logic [8:0] o_vcnt,
   output logic       o_hblank,
   output logic       o_vblank,
   output logic       o_sel_a,
   output logic       o_sel_an,
   output logic       o_sel_b,
   output logic       o_sel_bn,
   output logic       o_sel_c,
   output logic       o_sel_cn,
   output logic [5:0] o_col_fix,
   output logic [5:0] o_col_a,
   output logic [5:0] o_col_b,
   output logic [4:0] o_row_fix,
   output logic [4:0] o_row_a,
   output logic [4:0] o_row_b,
   output logic [1:0] o_arb_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT1 = 2'd1,
      ST_GRANT2 = 2'd2
   } arb_state_t;

   logic [8:0] r_hcnt;
   logic [8:0] r_vcnt;
   logic       r_hblank;
   logic       r_vblank;
   logic       r_sel_a, r_sel_an;
   logic       r_sel_b, r_sel_bn;
   logic       r_sel_c, r_sel_cn;
   logic [5:0] r_col_fix, r_col_a, r_col_b;
   logic [4:0] r_row_fix, r_row_a, r_row_b;
   arb_state_t r_arb_state;
   logic       r_cpu_ack;

   logic [8:0] w_hcnt_nxt;
   logic [8:0] w_vcnt_nxt;
   logic       w_hwrap;
   logic       w_hblank_nxt;
   logic       w_vblank_nxt;
   logic       w_blank_nxt;
   logic [2:0] w_phase_nxt;
   logic       w_grant_ok;

   // Position about to be entered on the next tick; every registered output
   // is decoded from this so it lines up with the counters it accompanies.
   always_comb begin
      w_hwrap      = (r_hcnt == 9'(H_TOTAL - 1));
      w_hcnt_nxt   = w_hwrap ? 9'd0 : r_hcnt + 9'd1;
      w_vcnt_nxt   = r_vcnt;
      if (w_hwrap) begin
         w_vcnt_nxt = (r_vcnt == 9'(V_TOTAL - 1)) ? 9'd0 : r_vcnt + 9'd1;
      end
      w_hblank_nxt = (w_hcnt_nxt >= 9'(H_ACTIVE));
      w_vblank_nxt = (w_vcnt_nxt >= 9'(V_ACTIVE));
      w_blank_nxt  = w_hblank_nxt | w_vblank_nxt;
      w_phase_nxt  = w_hcnt_nxt[2:0];
      // Even CPU-slot phases only, so a two-tick grant never spills into a
      // tile fetch slot.
      w_grant_ok   = ~w_phase_nxt[0] & (w_blank_nxt | (w_phase_nxt[2:1] == 2'b11));
   end

   // Raster counters and registered blanking flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hcnt   <= 9'd0;
         r_vcnt   <= 9'd0;
         r_hblank <= 1'b0;
         r_vblank <= 1'b0;
      end else if (i_pxl_en) begin
         r_hcnt   <= w_hcnt_nxt;
         r_vcnt   <= w_vcnt_nxt;
         r_hblank <= w_hblank_nxt;
         r_vblank <= w_vblank_nxt;
      end
   end

   // Slot select pairs; the complement registers are loaded with the exact
   // inverse so the pair stays complementary in every cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sel_c  <= 1'b1;
         r_sel_cn <= 1'b0;
         r_sel_a  <= 1'b0;
         r_sel_an <= 1'b1;
         r_sel_b  <= 1'b0;
         r_sel_bn <= 1'b1;
      end else if (i_pxl_en) begin
         r_sel_c  <= ~w_blank_nxt & (w_phase_nxt[2:1] == 2'b00);
         r_sel_cn <= ~(~w_blank_nxt & (w_phase_nxt[2:1] == 2'b00));
         r_sel_a  <= ~w_blank_nxt & (w_phase_nxt[2:1] == 2'b01);
         r_sel_an <= ~(~w_blank_nxt & (w_phase_nxt[2:1] == 2'b01));
         r_sel_b  <= ~w_blank_nxt & (w_phase_nxt[2:1] == 2'b10);
         r_sel_bn <= ~(~w_blank_nxt & (w_phase_nxt[2:1] == 2'b10));
      end
   end

   // Tile column/row operands, latched once per cell on entry to phase 0.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_col_fix <= 6'd0;
         r_row_fix <= 5'd0;
         r_col_a   <= 6'd0;
         r_row_a   <= 5'd0;
         r_col_b   <= 6'd0;
         r_row_b   <= 5'd0;
      end else if (i_pxl_en && (w_phase_nxt == 3'd0)) begin
         r_col_fix <= w_hcnt_nxt[8:3];
         r_row_fix <= w_vcnt_nxt[7:3];
         r_col_a   <= 6'((w_hcnt_nxt + i_scrx_a) >> 3);
         r_row_a   <= 5'((w_vcnt_nxt[7:0] + i_scry_a) >> 3);
         r_col_b   <= 6'((w_hcnt_nxt + i_scrx_b) >> 3);
         r_row_b   <= 5'((w_vcnt_nxt[7:0] + i_scry_b) >> 3);
      end
   end

   // CPU access arbiter with registered one-CLK completion pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_arb_state <= ST_IDLE;
         r_cpu_ack   <= 1'b0;
      end else begin
         r_cpu_ack <= 1'b0;
         if (i_pxl_en) begin
            case (r_arb_state)
               ST_IDLE: begin
                  if (i_cpu_req && w_grant_ok) begin
                     r_arb_state <= ST_GRANT1;
                  end
               end
               ST_GRANT1: r_arb_state <= ST_GRANT2;
               ST_GRANT2: begin
                  r_arb_state <= ST_IDLE;
                  r_cpu_ack   <= 1'b1;
               end
               default: r_arb_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_hcnt      = r_hcnt;
   assign o_vcnt      = r_vcnt;
   assign o_hblank    = r_hblank;
   assign o_vblank    = r_vblank;
   assign o_sel_a     = r_sel_a;
   assign o_sel_an    = r_sel_an;
   assign o_sel_b     = r_sel_b;
   assign o_sel_bn    = r_sel_bn;
   assign o_sel_c     = r_sel_c;
   assign o_sel_cn    = r_sel_cn;
   assign o_col_fix   = r_col_fix;
   assign o_col_a     = r_col_a;
   assign o_col_b     = r_col_b;
   assign o_row_fix   = r_row_fix;
   assign o_row_a     = r_row_a;
   assign o_row_b     = r_row_b;
   assign o_cpu_ack   = r_cpu_ack;
   assign o_arb_state = r_arb_state;

endmodule

// File: tb/tb_k052109_slot_seq.sv
// Bench for k052109_slot_seq. V_TOTAL/V_ACTIVE are shortened so frame-wrap
// and deep-line cases fit in a short run; horizontal timing keeps defaults.
module tb_k052109_slot_seq;

   localparam int V_TOT = 64;
   localparam int V_ACT = 56;

   localparam int F_HCNT = 0, F_VCNT = 1, F_HB = 2, F_VB = 3, F_SELC = 4, F_SELCN = 5,
                  F_SELA = 6, F_SELAN = 7, F_SELB = 8, F_SELBN = 9, F_ACK = 10,
                  F_COLFIX = 11, F_ROWFIX = 12, F_COLA = 13, F_ROWA = 14,
                  F_COLB = 15, F_ROWB = 16, F_STATE = 17;

   typedef struct {
      string      name;
      int         fld;
      logic [8:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, pxl_en, cpu_req;
   logic [8:0] scrx_a, scrx_b;
   logic [7:0] scry_a, scry_b;
   logic       cpu_ack, hblank, vblank;
   logic [8:0] hcnt, vcnt;
   logic       sel_a, sel_an, sel_b, sel_bn, sel_c, sel_cn;
   logic [5:0] col_fix, col_a, col_b;
   logic [4:0] row_fix, row_a, row_b;
   logic [1:0] arb_state;

   exp_t       exp_q[$];
   logic [8:0] ack_exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic       mon_en = 1'b0;
   event       chk_ev;

   k052109_slot_seq #(.V_TOTAL(V_TOT), .V_ACTIVE(V_ACT)) dut (
      .i_clk(clk), .i_rst(rst), .i_pxl_en(pxl_en),
      .i_scrx_a(scrx_a), .i_scry_a(scry_a), .i_scrx_b(scrx_b), .i_scry_b(scry_b),
      .i_cpu_req(cpu_req), .o_cpu_ack(cpu_ack),
      .o_hcnt(hcnt), .o_vcnt(vcnt), .o_hblank(hblank), .o_vblank(vblank),
      .o_sel_a(sel_a), .o_sel_an(sel_an), .o_sel_b(sel_b), .o_sel_bn(sel_bn),
      .o_sel_c(sel_c), .o_sel_cn(sel_cn),
      .o_col_fix(col_fix), .o_col_a(col_a), .o_col_b(col_b),
      .o_row_fix(row_fix), .o_row_a(row_a), .o_row_b(row_b),
      .o_arb_state(arb_state)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic logic [8:0] dut_field(input int f);
      case (f)
         F_HCNT:   return hcnt;
         F_VCNT:   return vcnt;
         F_HB:     return {8'd0, hblank};
         F_VB:     return {8'd0, vblank};
         F_SELC:   return {8'd0, sel_c};
         F_SELCN:  return {8'd0, sel_cn};
         F_SELA:   return {8'd0, sel_a};
         F_SELAN:  return {8'd0, sel_an};
         F_SELB:   return {8'd0, sel_b};
         F_SELBN:  return {8'd0, sel_bn};
         F_ACK:    return {8'd0, cpu_ack};
         F_COLFIX: return {3'd0, col_fix};
         F_ROWFIX: return {4'd0, row_fix};
         F_COLA:   return {3'd0, col_a};
         F_ROWA:   return {4'd0, row_a};
         F_COLB:   return {3'd0, col_b};
         F_ROWB:   return {4'd0, row_b};
         F_STATE:  return {7'd0, arb_state};
         default:  return 9'h1FF;
      endcase
   endfunction

   // Scoreboard monitor: drains expectations whenever a sample point is signalled
   initial begin
      exp_t e;
      logic [8:0] act;
      forever begin
         @(chk_ev);
         while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = dut_field(e.fld);
            checks++;
            if (act !== e.val) begin
               errors++;
               $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, act, e.val, $time);
            end
         end
      end
   end

   // Ack monitor: every ack pulse must match an expected completion position
   always @(negedge clk) begin
      if (mon_en && cpu_ack === 1'b1) begin
         checks++;
         if (ack_exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: ack=1 at hcnt %0d vcnt %0d, expected no ack", hcnt, vcnt);
         end else begin
            logic [8:0] eh;
            eh = ack_exp_q.pop_front();
            if (hcnt !== eh) begin
               errors++;
               $display("FAIL ack_position: ack at hcnt %0d, expected hcnt %0d", hcnt, eh);
            end
         end
      end
   end

   // Complement monitor: each *n output is the inverse of its pair every cycle
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if ({sel_an, sel_bn, sel_cn} !== ~{sel_a, sel_b, sel_c}) begin
            errors++;
            $display("FAIL sel_complement: a/an=%b%b b/bn=%b%b c/cn=%b%b, expected inverse pairs",
                     sel_a, sel_an, sel_b, sel_bn, sel_c, sel_cn);
         end
      end
   end

   // Driver tasks
   task automatic expect_f(input string nm, input int f, input logic [8:0] v);
      exp_q.push_back('{nm, f, v});
   endtask

   task automatic fire();
      -> chk_ev;
      #1;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic goto_pos(input int h, input int v);
      int n;
      n = 0;
      while (!(hcnt == 9'(h) && vcnt == 9'(v))) begin
         @(negedge clk);
         n++;
         if (n > 40000) begin
            checks++;
            errors++;
            $display("FAIL goto_timeout: at %0d/%0d, expected to reach %0d/%0d", hcnt, vcnt, h, v);
            break;
         end
      end
   endtask

   task automatic expect_sels(input string nm, input logic c, input logic a, input logic b);
      expect_f({nm, "_sel_c"}, F_SELC, {8'd0, c});
      expect_f({nm, "_sel_a"}, F_SELA, {8'd0, a});
      expect_f({nm, "_sel_b"}, F_SELB, {8'd0, b});
   endtask

   initial begin
      rst = 1'b1; pxl_en = 1'b1; cpu_req = 1'b0;
      scrx_a = 9'd0; scry_a = 8'd0; scrx_b = 9'd0; scry_b = 8'd0;
      repeat (3) step();

      // Reset state
      expect_f("rst_hcnt", F_HCNT, 9'd0);
      expect_f("rst_vcnt", F_VCNT, 9'd0);
      expect_f("rst_hb", F_HB, 9'd0);
      expect_f("rst_vb", F_VB, 9'd0);
      expect_sels("rst", 1'b1, 1'b0, 1'b0);
      expect_f("rst_sel_cn", F_SELCN, 9'd0);
      expect_f("rst_ack", F_ACK, 9'd0);
      expect_f("rst_colfix", F_COLFIX, 9'd0);
      expect_f("rst_cola", F_COLA, 9'd0);
      expect_f("rst_rowb", F_ROWB, 9'd0);
      expect_f("rst_state", F_STATE, 9'd0);
      fire();
      mon_en = 1'b1;
      rst = 1'b0;

      // Slot decode across one active cell
      for (int h = 1; h < 8; h++) begin
         step();
         expect_f("dec_hcnt", F_HCNT, 9'(h));
         expect_sels("dec", (h < 2), (h == 2 || h == 3), (h == 4 || h == 5));
         fire();
      end
      step();
      expect_f("dec_hcnt8", F_HCNT, 9'd8);
      expect_sels("dec8", 1'b1, 1'b0, 1'b0);
      expect_f("dec_colfix8", F_COLFIX, 9'd1);
      fire();
      goto_pos(330, 0);
      expect_sels("hblank330", 1'b0, 1'b0, 1'b0);
      expect_f("hblank330_hb", F_HB, 9'd1);
      expect_f("hblank330_vb", F_VB, 9'd0);
      fire();

      // Scroll wrap on line 5
      scrx_a = 9'd505; scry_a = 8'hFC; scrx_b = 9'd3; scry_b = 8'd10;
      goto_pos(7, 5);
      step();
      expect_f("scr8_cola", F_COLA, 9'd0);
      expect_f("scr8_rowa", F_ROWA, 9'd0);
      expect_f("scr8_colb", F_COLB, 9'd1);
      expect_f("scr8_rowb", F_ROWB, 9'd1);
      expect_f("scr8_colfix", F_COLFIX, 9'd1);
      fire();
      repeat (8) step();
      expect_f("scr16_hcnt", F_HCNT, 9'd16);
      expect_f("scr16_cola", F_COLA, 9'd1);
      expect_f("scr16_colb", F_COLB, 9'd2);
      expect_f("scr16_colfix", F_COLFIX, 9'd2);
      expect_f("scr16_rowfix", F_ROWFIX, 9'd0);
      fire();

      // Active-line CPU access
      goto_pos(3, 6);
      cpu_req = 1'b1;
      ack_exp_q.push_back(9'd8);
      step(); expect_f("act4_state", F_STATE, 9'd0); fire();
      step(); expect_f("act5_state", F_STATE, 9'd0); fire();
      step(); expect_f("act6_state", F_STATE, 9'd1); fire();
      step(); expect_f("act7_state", F_STATE, 9'd2); expect_f("act7_ack", F_ACK, 9'd0); fire();
      step(); expect_f("act8_state", F_STATE, 9'd0); expect_f("act8_ack", F_ACK, 9'd1); fire();
      cpu_req = 1'b0;
      step(); expect_f("act9_ack", F_ACK, 9'd0); fire();

      // Blank CPU access, back-to-back
      goto_pos(330, 6);
      cpu_req = 1'b1;
      ack_exp_q.push_back(9'd334);
      ack_exp_q.push_back(9'd338);
      step(); expect_f("blk331_state", F_STATE, 9'd0); fire();
      step(); expect_f("blk332_state", F_STATE, 9'd1); fire();
      step(); expect_f("blk333_state", F_STATE, 9'd2); fire();
      step(); expect_f("blk334_state", F_STATE, 9'd0); expect_f("blk334_ack", F_ACK, 9'd1); fire();
      step(); expect_f("blk335_state", F_STATE, 9'd0); expect_f("blk335_ack", F_ACK, 9'd0); fire();
      step(); expect_f("blk336_state", F_STATE, 9'd1); fire();
      step(); expect_f("blk337_state", F_STATE, 9'd2); fire();
      step(); expect_f("blk338_state", F_STATE, 9'd0); fire();
      cpu_req = 1'b0;
      repeat (4) step();
      expect_f("blk_idle_state", F_STATE, 9'd0); fire();

      // Reset mid-grant: no ack may follow
      goto_pos(3, 7);
      cpu_req = 1'b1;
      goto_pos(6, 7);
      expect_f("mg_state", F_STATE, 9'd1); fire();
      rst = 1'b1; cpu_req = 1'b0;
      step();
      rst = 1'b0;
      expect_f("mg_hcnt", F_HCNT, 9'd0);
      expect_f("mg_vcnt", F_VCNT, 9'd0);
      expect_f("mg_state0", F_STATE, 9'd0);
      expect_f("mg_ack", F_ACK, 9'd0);
      fire();
      repeat (20) step();

      // Reset mid-frame
      goto_pos(200, 50);
      rst = 1'b1;
      step();
      rst = 1'b0;
      expect_f("mf_hcnt", F_HCNT, 9'd0);
      expect_f("mf_vcnt", F_VCNT, 9'd0);
      expect_sels("mf", 1'b1, 1'b0, 1'b0);
      expect_f("mf_sel_cn", F_SELCN, 9'd0);
      expect_f("mf_ack", F_ACK, 9'd0);
      expect_f("mf_colfix", F_COLFIX, 9'd0);
      fire();

      // Vertical blank
      goto_pos(0, V_ACT);
      expect_f("vb_vb", F_VB, 9'd1);
      expect_f("vb_hb", F_HB, 9'd0);
      expect_sels("vb0", 1'b0, 1'b0, 1'b0);
      expect_f("vb_rowfix", F_ROWFIX, 9'd7);
      fire();

      // Frame wrap
      goto_pos(383, V_TOT - 1);
      expect_f("fw_pre_hb", F_HB, 9'd1);
      expect_f("fw_pre_vb", F_VB, 9'd1);
      fire();
      step();
      expect_f("fw_hcnt", F_HCNT, 9'd0);
      expect_f("fw_vcnt", F_VCNT, 9'd0);
      expect_f("fw_hb", F_HB, 9'd0);
      expect_f("fw_vb", F_VB, 9'd0);
      expect_sels("fw", 1'b1, 1'b0, 1'b0);
      expect_f("fw_colfix", F_COLFIX, 9'd0);
      expect_f("fw_rowfix", F_ROWFIX, 9'd0);
      fire();

      // Pixel enable low: everything holds
      pxl_en = 1'b0;
      repeat (5) step();
      expect_f("hold_hcnt", F_HCNT, 9'd0);
      expect_f("hold_vcnt", F_VCNT, 9'd0);
      expect_sels("hold", 1'b1, 1'b0, 1'b0);
      expect_f("hold_ack", F_ACK, 9'd0);
      expect_f("hold_state", F_STATE, 9'd0);
      fire();
      pxl_en = 1'b1;
      step();
      expect_f("resume_hcnt", F_HCNT, 9'd1);
      fire();

      repeat (2) step();
      if (ack_exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL missing_ack: %0d acks outstanding, expected 0", ack_exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
